reservation_station: RTL
========================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter: SZ, 8, number of entries in this bank.
REQ-002 SHALL have parameter: NUM_ALLOC, 2, dispatch write ports per cycle.
REQ-003 SHALL have parameter: NUM_CLEAR, 2, issue clear ports per cycle (equal to the FU count of the category).
REQ-004 SHALL have parameter: CDB_WIDTH, 3, wakeup broadcasts per cycle.
REQ-005 SHALL have port: clock  in  1  clock, rising edge.
REQ-006 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port: mispredict  in  1  flush all entries.
REQ-008 SHALL have port: alloc_valid  in  NUM_ALLOC  per-port dispatch request.
REQ-009 SHALL have port: alloc_entries  in  NUM_ALLOC x RS_ENTRY  dispatched entries.
REQ-010 SHALL have port: clear_valid  in  NUM_CLEAR  per-port issue clear, from the issue stage.
REQ-011 SHALL have port: clear_idxs  in  NUM_CLEAR x RS_IDX  local bank index to clear.
REQ-012 SHALL have port: cdb_valid  in  CDB_WIDTH  broadcast valid.
REQ-013 SHALL have port: cdb_tags  in  CDB_WIDTH x PHYS_TAG  completing physical tags.
REQ-014 SHALL have port: entries  out  SZ x RS_ENTRY  registered bank contents, to the issue stage.
REQ-015 SHALL have port: free_slots  out  $clog2(SZ+1)  registered count of invalid entries.

Function
REQ-016 SHALL drive entries and free_slots directly from registers, with no combinational path from any input.
REQ-017 SHALL place the valid alloc ports, in ascending port order, into the lowest-index entries that are invalid this cycle; the entries are written at the next edge.
REQ-018 SHALL flag an error (simulation assertion) when the popcount of alloc_valid exceeds free_slots; the overflow ports are dropped.
REQ-019 SHALL invalidate entry clear_idxs[k] at the next edge when clear_valid[k] is set; clearing an already-invalid entry is a no-op.
REQ-020 SHALL make a slot cleared in cycle N unavailable for allocation until cycle N+1, since free-slot selection uses current valid bits only.
REQ-021 SHALL set src1_ready (src2_ready) of every valid entry at the next edge when its src1_tag (src2_tag) equals any cdb_tags[j] with cdb_valid[j] set; ready bits never clear while the entry is valid.
REQ-022 SHALL apply wakeup and clear in the same cycle independently, with clear taking precedence on the same entry.
REQ-023 SHALL set free_slots at each edge to SZ minus the popcount of the next-state valid bits.
REQ-024 SHALL, when mispredict is asserted, invalidate all entries at the next edge and ignore alloc, clear and wakeup that cycle; free_slots becomes SZ.

Reset
REQ-025 SHALL, on reset, clear every entry to all-zero (valid=0) and set free_slots to SZ.
REQ-026 SHALL give reset priority over mispredict, alloc, clear and wakeup; reset mid-operation discards all state.

Configuration
REQ-027 SHALL, with RS_DISPATCH_WAKEUP_EN defined, OR the same-cycle CDB tag match into src1_ready/src2_ready of entries written through the alloc ports.
REQ-028 SHALL, without RS_DISPATCH_WAKEUP_EN, write alloc_entries unmodified; the dispatch stage then owns same-cycle CDB forwarding.

Structure
REQ-029 SHALL take RS_ENTRY, RS_IDX and PHYS_TAG from sys_defs.svh; SZ defaults come from the per-category RS_*_SZ constants there.
REQ-030 SHALL implement free-slot selection in one sub-module, rs_free_selector (first-NUM_ALLOC-zeros priority selector over the valid vector).

Verification
REQ-031 SHALL cover: reset -> all entries valid=0, free_slots=8.
REQ-032 SHALL cover: alloc on both ports into an empty bank -> entries 0 and 1 valid next cycle, free_slots=6.
REQ-033 SHALL cover: entry 3 waiting on tag 17, cdb_valid[1]=1 with tag 17 -> src ready next cycle; tag 18 -> no change.
REQ-034 SHALL cover: 7 entries valid, clear idx 2 plus one alloc in the same cycle -> alloc lands in idx 7, idx 2 invalid, free_slots=1.
REQ-035 SHALL cover: alloc with src tag 5 while CDB broadcasts tag 5 -> ready=1 with the macro defined, ready=0 without it.
REQ-036 SHALL cover: full bank, mispredict plus alloc plus clear -> all entries invalid next cycle, free_slots=8.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared issue-queue types: physical tags, bank indices and the reservation-station entry layout.
package reservation_station_pkg;

  localparam int PHYS_TAG_W = 6;
  localparam int RS_ALU_SZ  = 8;
  localparam int RS_MULT_SZ = 4;
  localparam int RS_MEM_SZ  = 8;

  typedef logic [PHYS_TAG_W-1:0]        PHYS_TAG;
  typedef logic [$clog2(RS_ALU_SZ)-1:0] RS_IDX;

  typedef struct packed {
    logic       valid;
    logic [3:0] opcode;
    PHYS_TAG    dest_tag;
    PHYS_TAG    src1_tag;
    logic       src1_ready;
    PHYS_TAG    src2_tag;
    logic       src2_ready;
  } RS_ENTRY;

  localparam int RS_ENTRY_W = $bits(RS_ENTRY);

endpackage

// File: rtl/reservation_station_free_selector.sv
// rs_free_selector: picks the first NUM_ALLOC invalid slots of the bank, lowest index first.
module rs_free_selector #(
  parameter int SZ        = 8,
  parameter int NUM_ALLOC = 2
) (
  input  logic [SZ-1:0]                   valid,
  output logic [NUM_ALLOC-1:0]            sel_valid,
  output logic [NUM_ALLOC*$clog2(SZ)-1:0] sel_idx
);
  localparam int IDX_W = $clog2(SZ);

  int w_zeros;

  always_comb begin
    sel_valid = '0;
    sel_idx   = '0;
    w_zeros   = 0;
    for (int i = 0; i < SZ; i++) begin
      if (!valid[i]) begin
        // The k-th zero seen in ascending order feeds allocation port rank k.
        for (int k = 0; k < NUM_ALLOC; k++) begin
          if (w_zeros == k) begin
            sel_valid[k]                 = 1'b1;
            sel_idx[k*IDX_W +: IDX_W]    = IDX_W'(i);
          end
        end
        w_zeros = w_zeros + 1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation-station bank: dispatch alloc, issue clear, CDB wakeup and mispredict flush.
// Build option RS_DISPATCH_WAKEUP_EN folds same-cycle CDB matches into newly allocated entries.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int SZ        = RS_ALU_SZ,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_CLEAR = 2,
  parameter int CDB_WIDTH = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              mispredict,
  input  logic [NUM_ALLOC-1:0]              alloc_valid,
  input  logic [NUM_ALLOC*RS_ENTRY_W-1:0]   alloc_entries,
  input  logic [NUM_CLEAR-1:0]              clear_valid,
  input  logic [NUM_CLEAR*$clog2(SZ)-1:0]   clear_idxs,
  input  logic [CDB_WIDTH-1:0]              cdb_valid,
  input  logic [CDB_WIDTH*PHYS_TAG_W-1:0]   cdb_tags,
  output logic [SZ*RS_ENTRY_W-1:0]          entries,
  output logic [$clog2(SZ+1)-1:0]           free_slots
);
  localparam int IDX_W = $clog2(SZ);
  localparam int FS_W  = $clog2(SZ+1);

  RS_ENTRY [SZ-1:0]        r_entries;
  RS_ENTRY [SZ-1:0]        w_next;
  RS_ENTRY [NUM_ALLOC-1:0] w_alloc;
  RS_ENTRY                 w_new;
  logic [FS_W-1:0]         r_free;
  logic [FS_W-1:0]         w_free;
  logic [SZ-1:0]           w_valid;
  logic [NUM_ALLOC-1:0]    w_sel_valid;
  logic [NUM_ALLOC*IDX_W-1:0] w_sel_idx;
  int                      w_rank;
  int                      w_cnt;

  function automatic logic cdb_hit(input PHYS_TAG tag,
                                   input logic [CDB_WIDTH-1:0] vld,
                                   input logic [CDB_WIDTH*PHYS_TAG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int j = 0; j < CDB_WIDTH; j++)
      if (vld[j] && (tags[j*PHYS_TAG_W +: PHYS_TAG_W] == tag)) cdb_hit = 1'b1;
  endfunction

  assign w_alloc = alloc_entries;

  always_comb begin
    for (int i = 0; i < SZ; i++) w_valid[i] = r_entries[i].valid;
  end

  rs_free_selector #(
    .SZ        (SZ),
    .NUM_ALLOC (NUM_ALLOC)
  ) u_free_sel (
    .valid     (w_valid),
    .sel_valid (w_sel_valid),
    .sel_idx   (w_sel_idx)
  );

  // Next-state bank contents
  always_comb begin
    w_next = r_entries;
    w_new  = '0;
    w_rank = 0;
    w_cnt  = 0;

    for (int i = 0; i < SZ; i++) begin
      if (w_next[i].valid) begin
        if (cdb_hit(w_next[i].src1_tag, cdb_valid, cdb_tags)) w_next[i].src1_ready = 1'b1;
        if (cdb_hit(w_next[i].src2_tag, cdb_valid, cdb_tags)) w_next[i].src2_ready = 1'b1;
      end
    end

    for (int k = 0; k < NUM_CLEAR; k++)
      if (clear_valid[k]) w_next[clear_idxs[k*IDX_W +: IDX_W]].valid = 1'b0;

    // Selected slots were invalid this cycle, so a slot cleared now is never reused until next cycle.
    for (int p = 0; p < NUM_ALLOC; p++) begin
      if (alloc_valid[p]) begin
        for (int k = 0; k < NUM_ALLOC; k++) begin
          if ((w_rank == k) && w_sel_valid[k]) begin
            w_new       = w_alloc[p];
            w_new.valid = 1'b1;
`ifdef RS_DISPATCH_WAKEUP_EN
            w_new.src1_ready = w_new.src1_ready | cdb_hit(w_new.src1_tag, cdb_valid, cdb_tags);
            w_new.src2_ready = w_new.src2_ready | cdb_hit(w_new.src2_tag, cdb_valid, cdb_tags);
`endif
            w_next[w_sel_idx[k*IDX_W +: IDX_W]] = w_new;
          end
        end
        w_rank = w_rank + 1;
      end
    end

    if (mispredict)
      for (int i = 0; i < SZ; i++) w_next[i].valid = 1'b0;

    for (int i = 0; i < SZ; i++)
      if (w_next[i].valid) w_cnt = w_cnt + 1;
    w_free = FS_W'(SZ - w_cnt);
  end

  // Bank register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      r_entries <= '0;
      r_free    <= FS_W'(SZ);
    end else begin
      r_entries <= w_next;
      r_free    <= w_free;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !mispredict)
      assert ($countones(alloc_valid) <= int'(r_free))
        else $error("reservation_station: alloc request exceeds free slots");
  end

  assign entries    = r_entries;
  assign free_slots = r_free;

endmodule
